// File: rtl/mul_div_unit_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states, op-class helper.
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_e;

    // MULT, MULTU, DIV and DIVU occupy codes 0..3 and are the only iterative ops.
    function automatic logic is_iter_op(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Bus between the execute-stage control and the multiply/divide unit.
interface mul_div_unit_if #(parameter int WIDTH = 32);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (output start, op, A, B, input busy, done, HI, LO);
    modport slave  (input start, op, A, B, output busy, done, HI, LO);
endinterface

// File: rtl/mul_div_unit_datapath.sv
// Magnitude shift-add multiplier / restoring divider sharing one 2*WIDTH accumulator,
// plus the sign fix-up applied to the final result.
module mdu_datapath #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               div_q, div_d;
    logic               neg_prod_q, neg_prod_d;
    logic               neg_quot_q, neg_quot_d;
    logic               neg_rem_q, neg_rem_d;

    logic               sa, sb;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     sub_res;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot, rem;

    // Load magnitudes on start, then advance one multiply or divide step per cycle.
    always_comb begin
        sa         = is_signed & a[WIDTH-1];
        sb         = is_signed & b[WIDTH-1];
        mag_a      = sa ? (~a + 1'b1) : a;
        mag_b      = sb ? (~b + 1'b1) : b;
        add_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                     (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        rem_sh     = acc_q[2*WIDTH-1:WIDTH-1];
        sub_res    = rem_sh - {1'b0, opnd_q};
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        div_d      = div_q;
        neg_prod_d = neg_prod_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        if (load) begin
            acc_d      = {{WIDTH{1'b0}}, mag_a};
            opnd_d     = mag_b;
            div_d      = is_div;
            neg_prod_d = sa ^ sb;
            // A zero divisor yields an all-ones quotient regardless of signs.
            neg_quot_d = (sa ^ sb) & (b != '0);
            neg_rem_d  = sa;
        end else if (step) begin
            if (div_q) begin
                // Compare rather than test the borrow: with a zero divisor the
                // shifted remainder may carry into bit WIDTH and must still subtract.
                if (rem_sh >= {1'b0, opnd_q}) begin
                    acc_d = {sub_res[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                acc_d = {add_sum, acc_q[WIDTH-1:1]};
            end
        end
    end

    // Accumulator, operand and sign-flag registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_q      <= '0;
            opnd_q     <= '0;
            div_q      <= 1'b0;
            neg_prod_q <= 1'b0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            div_q      <= div_d;
            neg_prod_q <= neg_prod_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
        end
    end

    // Sign fix-up of the finished magnitude result.
    always_comb begin
        prod   = neg_prod_q ? (~acc_q + 1'b1) : acc_q;
        quot   = acc_q[WIDTH-1:0];
        rem    = acc_q[2*WIDTH-1:WIDTH];
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (div_q) begin
            res_hi = neg_rem_q  ? (~rem + 1'b1)  : rem;
            res_lo = neg_quot_q ? (~quot + 1'b1) : quot;
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// MIPS multiply/divide unit: control FSM, iteration counter and the HI/LO registers.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rstn,
    mul_div_unit_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             dp_load, dp_step;
    logic [WIDTH-1:0] dp_hi, dp_lo;

    mdu_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk       (clk),
        .rstn      (rstn),
        .load      (dp_load),
        .step      (dp_step),
        .is_div    (is_div_op(bus.op)),
        .is_signed (is_signed_op(bus.op)),
        .a         (bus.A),
        .b         (bus.B),
        .res_hi    (dp_hi),
        .res_lo    (dp_lo)
    );

    // State, counter, HI/LO and done registers; reset aborts any running op.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    // Next state: IDLE -> RUN for WIDTH steps -> FIN for one cycle -> IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start && is_iter_op(bus.op)) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_FIN;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: datapath controls, HI/LO writes (MTHI/MTLO only when idle) and done.
    always_comb begin
        dp_load = 1'b0;
        dp_step = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    dp_load = is_iter_op(bus.op);
                    if (bus.op == OP_MTHI) hi_d = bus.A;
                    if (bus.op == OP_MTLO) lo_d = bus.A;
                end
            end
            S_RUN: dp_step = 1'b1;
            S_FIN: begin
                hi_d   = dp_hi;
                lo_d   = dp_lo;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.busy = (state_q != S_IDLE);
    assign bus.done = done_q;
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed table, corner sequences, random ops.
module tb_mul_div_unit;
    import mdu_pkg::*;

    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    mul_div_unit_if #(.WIDTH(WIDTH)) bus ();

    mul_div_unit #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h", nm, act, req);
        end
    endtask

    // Reference behaviour from plain 64-bit arithmetic.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo);
        longint sa, sb, q, r;
        logic [63:0] p;
        hi = exp_hi;
        lo = exp_lo;
        sa = $signed({{32{a[31]}}, a});
        sb = $signed({{32{b[31]}}, b});
        case (op)
            3'd0: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
            3'd1: begin p = {32'b0, a} * {32'b0, b}; hi = p[63:32]; lo = p[31:0]; end
            3'd2, 3'd3: begin
                if (b == 0) begin
                    lo = 32'hFFFF_FFFF;
                    hi = a;
                end else begin
                    if (op == 3'd3) begin
                        sa = longint'({32'b0, a});
                        sb = longint'({32'b0, b});
                    end
                    q = sa / sb;
                    r = sa % sb;
                    lo = q[31:0];
                    hi = r[31:0];
                end
            end
            3'd4: hi = a;
            3'd5: lo = a;
            default: ;
        endcase
    endtask

    // Issue one op from idle and check latency, handshake and HI/LO.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input string nm);
        int n;
        bus.start = 1'b1;
        bus.op    = op;
        bus.A     = a;
        bus.B     = b;
        @(negedge clk);
        bus.start = 1'b0;
        n = 1;
        if (op[2] == 1'b0) begin
            while (!bus.done && n < WIDTH + 10) begin
                @(negedge clk);
                n++;
            end
            chk({nm, " latency"}, 32'(n), 32'(WIDTH + 2));
        end else begin
            chk({nm, " done"}, 32'(bus.done), 32'd0);
        end
        chk({nm, " busy"}, 32'(bus.busy), 32'd0);
        chk({nm, " HI"}, bus.HI, eh);
        chk({nm, " LO"}, bus.LO, el);
        exp_hi = eh;
        exp_lo = el;
        if (op[2] == 1'b0) begin
            @(negedge clk);
            chk({nm, " done pulse"}, 32'(bus.done), 32'd0);
        end
    endtask

    initial begin
        vec_t vecs[$];
        int   n, pulses;
        logic [31:0] eh, el;

        vecs.push_back('{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
        vecs.push_back('{3'd0, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1});
        vecs.push_back('{3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD});
        vecs.push_back('{3'd3, 32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF});
        vecs.push_back('{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000});
        vecs.push_back('{3'd2, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD});
        vecs.push_back('{3'd2, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF});
        vecs.push_back('{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000});
        vecs.push_back('{3'd3, 32'hFFFF_FFFF, 32'd16,        32'h0000_000F, 32'h0FFF_FFFF});
        vecs.push_back('{3'd4, 32'h1234_5678, 32'd0,         32'h1234_5678, 32'h0FFF_FFFF});
        vecs.push_back('{3'd5, 32'hCAFE_F00D, 32'd0,         32'h1234_5678, 32'hCAFE_F00D});
        vecs.push_back('{3'd7, 32'h1111_1111, 32'd3,         32'h1234_5678, 32'hCAFE_F00D});

        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.A     = '0;
        bus.B     = '0;
        repeat (3) @(negedge clk);
        chk("reset HI", bus.HI, 32'd0);
        chk("reset LO", bus.LO, 32'd0);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo,
                   $sformatf("vec%0d", i));
        end

        // DIVU 17/5 with spurious starts and wandering operands during RUN.
        bus.start = 1'b1; bus.op = OP_DIVU; bus.A = 32'd17; bus.B = 32'd5;
        @(negedge clk);
        n = 1; pulses = 0;
        while (n < WIDTH + 6) begin
            bus.start = (n == 5 || n == 20);
            bus.op    = OP_MULT;
            bus.A     = $urandom;
            bus.B     = $urandom;
            if (n == 10) chk("ign HI hold", bus.HI, exp_hi);
            if (n == 10) chk("ign busy", 32'(bus.busy), 32'd1);
            if (bus.done) begin
                pulses++;
                chk("ign latency", 32'(n), 32'(WIDTH + 2));
                chk("ign LO", bus.LO, 32'd3);
                chk("ign HI", bus.HI, 32'd2);
            end
            @(negedge clk);
            n++;
        end
        bus.start = 1'b0;
        chk("ign done pulses", 32'(pulses), 32'd1);
        exp_hi = 32'd2; exp_lo = 32'd3;

        // MTLO issued mid-operation must be dropped.
        bus.start = 1'b1; bus.op = OP_MULTU; bus.A = 32'd6; bus.B = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        n = 1;
        while (!bus.done && n < WIDTH + 10) begin
            bus.start = (n == 5); bus.op = OP_MTLO; bus.A = 32'hDEAD_BEEF;
            @(negedge clk);
            n++;
        end
        bus.start = 1'b0;
        chk("mtlo-busy LO", bus.LO, 32'd42);
        chk("mtlo-busy HI", bus.HI, 32'd0);
        exp_hi = 32'd0; exp_lo = 32'd42;

        // Start accepted in the done cycle.
        bus.start = 1'b1; bus.op = OP_MULTU; bus.A = 32'd3; bus.B = 32'd4;
        @(negedge clk);
        bus.start = 1'b0;
        n = 1;
        while (!bus.done && n < WIDTH + 10) begin @(negedge clk); n++; end
        chk("b2b first LO", bus.LO, 32'd12);
        bus.start = 1'b1; bus.op = OP_DIVU; bus.A = 32'd30; bus.B = 32'd4;
        @(negedge clk);
        bus.start = 1'b0;
        n = 1;
        while (!bus.done && n < WIDTH + 10) begin @(negedge clk); n++; end
        chk("b2b latency", 32'(n), 32'(WIDTH + 2));
        chk("b2b LO", bus.LO, 32'd7);
        chk("b2b HI", bus.HI, 32'd2);
        exp_hi = 32'd2; exp_lo = 32'd7;
        @(negedge clk);

        // Asynchronous reset while a multiply is at counter 10.
        bus.start = 1'b1; bus.op = OP_MULTU; bus.A = 32'hFFFF_FFFF; bus.B = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("abort busy", 32'(bus.busy), 32'd0);
        chk("abort HI", bus.HI, 32'd0);
        chk("abort LO", bus.LO, 32'd0);
        chk("abort done", 32'(bus.done), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        exp_hi = '0; exp_lo = '0;
        @(negedge clk);
        run_op(OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, "post-reset");

        // Random ops against the arithmetic model.
        for (int i = 0; i < 60; i++) begin
            logic [2:0]  rop;
            logic [31:0] ra, rb;
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
            model(rop, ra, rb, eh, el);
            run_op(rop, ra, rb, eh, el, $sformatf("rand%0d op%0d", i, rop));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit in the execute stage, directly downstream of the register file. It consumes the two register-file read ports as operands A and B.
- Implements MIPS MULT, MULTU, DIV, DIVU, MTHI and MTLO against private HI/LO registers.
- HI/LO outputs feed the MFHI/MFLO path back toward register-file writeback.
- Busy/done outputs let the control unit stall the pipeline while an operation runs.

Parameters:
- WIDTH, 32, operand and HI/LO width; the iteration count equals WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  launch the operation selected by op. Sampled only when busy=0.
- op  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO. 6 and 7 are no-ops.
- A  in  WIDTH  operand 1 (rs value). Dividend for DIV/DIVU; write data for MTHI/MTLO.
- B  in  WIDTH  operand 2 (rt value). Divisor for DIV/DIVU.
- busy  out  1  high while an iterative operation is in progress.
- done  out  1  one-cycle pulse when HI/LO take a MULT/DIV result.
- HI  out  WIDTH  HI register; remainder or upper product.
- LO  out  WIDTH  LO register; quotient or lower product.

Behaviour:
- Reset (rstn=0, asynchronous):
  - HI=0, LO=0, busy=0, done=0, state=IDLE.
  - Any in-flight operation is aborted without writing HI/LO.
- States:
  - IDLE: waits for a start.
  - RUN: runs the iteration counter.
  - FIN: performs sign fix-up and writes HI/LO.
- IDLE, start=1, op in {MTHI, MTLO}:
  - A is written to HI or LO at that edge; stay in IDLE.
  - busy and done stay 0.
- IDLE, start=1, op in MULT..DIVU:
  - At that edge, latch the operands and the signed flag, and load the magnitudes (two's-complement absolute value when signed).
  - Record the result signs:
    - product sign = A[msb] xor B[msb];
    - quotient sign = A[msb] xor B[msb];
    - remainder sign = A[msb].
  - Clear the counter and go to RUN.
- RUN, busy=1:
  - Multiply: one shift-add step per cycle on a 2*WIDTH accumulator.
  - Divide: one restoring shift-subtract step per cycle.
  - After WIDTH cycles, go to FIN.
- FIN, busy=1, one cycle:
  - Negate the results where the sign flags require it.
  - Write HI/LO at the exiting edge; done=1 in the following cycle, together with busy=0 and state=IDLE.
- Latency: start at edge t gives busy=1 for cycles t+1 .. t+WIDTH+1 and done=1 in cycle t+WIDTH+2. New HI/LO are visible in that same cycle.
- start while busy=1 is ignored; op, A and B changing during RUN have no effect.
- start in the same cycle as done is accepted, because busy=0 then.
- Products:
  - MULT gives the signed 2*WIDTH product; MULTU gives the unsigned product.
  - HI = upper WIDTH bits, LO = lower WIDTH bits.
- Quotient rounds toward zero; the remainder takes the sign of the dividend.
- Divide by zero (B=0), signed or unsigned: LO=all ones, HI=A. No exception.
- Signed overflow (A=0x80000000, B=0xFFFFFFFF): LO=0x80000000, HI=0. This falls out of magnitude arithmetic modulo 2^WIDTH.
- HI/LO change only at the FIN exit or on MTHI/MTLO. Otherwise they hold their value, including while busy.

Decomposition:
- Shared package mdu_pkg holds:
  - the op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO);
  - the state encodings (S_IDLE, S_RUN, S_FIN).
- The control decoder imports the same package.
- Natural sub-module: mdu_datapath. It holds the accumulator, the shift/add/subtract step and the sign fix-up.
- The top level keeps the FSM, the counter and the HI/LO registers.

Test Plan:
- MULTU with A=0xFFFFFFFF, B=0xFFFFFFFF -> after done: HI=0xFFFFFFFE, LO=0x00000001. Check done arrives exactly WIDTH+2 cycles after start.
- MULT with A=0xFFFFFFFD (-3), B=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. Then DIV with A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU with A=100, B=0 -> LO=0xFFFFFFFF, HI=0x00000064. DIV with A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- Start DIVU 17/5, pulse start again with op=MULT mid-RUN, and change A/B every cycle -> result is still LO=3, HI=2 with a single done pulse.
- MTHI with A=0x12345678 while idle -> HI updates next edge, busy stays 0. Later MTLO issued while busy -> ignored; LO keeps the running op's result.
- Start MULTU, deassert rstn at counter=10 -> busy=0, HI=LO=0 immediately. After release, a fresh MULTU 6*7 gives LO=42, HI=0.
